// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: requester ids, arbitration state and read-return tags.
package mem_arb_pkg;

   localparam int DATA_W   = 8;
   localparam int STREAK_W = 4;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_DMA = 1'b1
   } req_id_e;

   typedef enum logic {
      PRIO_CPU  = 1'b0,
      FORCE_DMA = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic    valid;
      req_id_e id;
   } tag_t;

   localparam tag_t TAG_NONE = '{valid: 1'b0, id: REQ_CPU};

   function automatic tag_t make_tag(input logic valid, input req_id_e id);
      tag_t t;
      t.valid = valid;
      t.id    = id;
      return t;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of CPU, DMA and memory-side signals around the arbiter.
// slave is the arbiter's view; master is the view of the requesters and memory.
interface mem_arbiter_if #(
   parameter int ADDR_W = 15
) ();
   import mem_arb_pkg::*;

   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;

   logic              dma_req;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_gnt;
   logic              dma_rvalid;
   logic [DATA_W-1:0] dma_rdata;

   logic              mem_we;
   logic              mem_oe;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              prot_err;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_gnt, dma_rvalid, dma_rdata,
      output mem_we, mem_oe, mem_addr, mem_wdata,
      input  mem_rdata,
      output prot_err
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_gnt, dma_rvalid, dma_rdata,
      input  mem_we, mem_oe, mem_addr, mem_wdata,
      output mem_rdata,
      input  prot_err
   );

endinterface

// File: rtl/mem_arb_tag_pipe.sv
// Shift register of read tags that follows each read from grant to data return.
// o_tap is the stage aligned with valid memory data; o_tag is the stage aligned with rvalid.
module mem_arb_tag_pipe
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic clk,
   input  logic reset,
   input  tag_t i_tag,
   output tag_t o_tap,
   output tag_t o_tag
);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         tag_t r_q;
         tag_t w_d;

         if (gi == 0) begin : g_head
            assign w_d = i_tag;
         end else begin : g_link
            assign w_d = g_stage[gi-1].r_q;
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_q <= TAG_NONE;
            end else begin
               r_q <= w_d;
            end
         end
      end
   endgenerate

   assign o_tap = g_stage[DEPTH-2].r_q;
   assign o_tag = g_stage[DEPTH-1].r_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the shared program/data memory between the 6502 core and the DMA/video engine.
// Optional write protection above ROM_BASE is enabled by defining MEM_ARB_WRPROT_EN.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int                ADDR_W         = 15,
   parameter int                READ_LATENCY   = 2,
   parameter int                MAX_CPU_STREAK = 4,
   parameter logic [ADDR_W-1:0] ROM_BASE       = 15'h6000
) (
   input  logic         clk,
   input  logic         reset,
   mem_arbiter_if.slave bus
);

   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CPU_STREAK);

   arb_state_e          r_state;
   logic [STREAK_W-1:0] r_streak;
   logic [STREAK_W-1:0] w_streak_next;

   logic                w_cpu_gnt;
   logic                w_dma_gnt;
   logic                w_any_gnt;
   logic                w_sel_we;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;
   logic                w_wr_blocked;

   logic                r_mem_we;
   logic                r_mem_oe;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;

   tag_t                w_tag_in;
   tag_t                w_tag_tap;
   tag_t                w_tag_out;
   logic [DATA_W-1:0]   r_cpu_rdata;
   logic [DATA_W-1:0]   r_dma_rdata;

   // In FORCE_DMA the priority order simply flips for one cycle.
   always_comb begin
      w_cpu_gnt = 1'b0;
      w_dma_gnt = 1'b0;
      if (r_state == FORCE_DMA) begin
         w_dma_gnt = bus.dma_req;
         w_cpu_gnt = bus.cpu_req & ~bus.dma_req;
      end else begin
         w_cpu_gnt = bus.cpu_req;
         w_dma_gnt = bus.dma_req & ~bus.cpu_req;
      end
   end

   assign w_any_gnt   = w_cpu_gnt | w_dma_gnt;
   assign bus.cpu_gnt = w_cpu_gnt;
   assign bus.dma_gnt = w_dma_gnt;

   always_comb begin
      w_streak_next = r_streak;
      if (!bus.dma_req || w_dma_gnt) begin
         w_streak_next = '0;
      end else if (w_cpu_gnt && (r_streak != STREAK_MAX)) begin
         w_streak_next = r_streak + STREAK_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= PRIO_CPU;
         r_streak <= '0;
      end else begin
         r_streak <= w_streak_next;
         case (r_state)
            PRIO_CPU: begin
               if (bus.dma_req && (w_streak_next == STREAK_MAX)) begin
                  r_state <= FORCE_DMA;
               end
            end
            FORCE_DMA: r_state <= PRIO_CPU;
            default:   r_state <= PRIO_CPU;
         endcase
      end
   end

   assign w_sel_we    = w_dma_gnt ? bus.dma_we    : bus.cpu_we;
   assign w_sel_addr  = w_dma_gnt ? bus.dma_addr  : bus.cpu_addr;
   assign w_sel_wdata = w_dma_gnt ? bus.dma_wdata : bus.cpu_wdata;

`ifdef MEM_ARB_WRPROT_EN
   logic r_prot_err;

   // A protected write still consumes its slot; only the strobe is suppressed.
   assign w_wr_blocked = w_any_gnt && w_sel_we && (w_sel_addr >= ROM_BASE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prot_err <= 1'b0;
      end else if (w_wr_blocked) begin
         r_prot_err <= 1'b1;
      end
   end

   assign bus.prot_err = r_prot_err;
`else
   logic [ADDR_W-1:0] w_unused_rom_base;

   assign w_unused_rom_base = ROM_BASE;
   assign w_wr_blocked      = 1'b0;
   assign bus.prot_err      = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem_we    <= 1'b0;
         r_mem_oe    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_mem_we <= w_any_gnt && w_sel_we && !w_wr_blocked;
         r_mem_oe <= w_any_gnt && !w_sel_we;
         if (w_any_gnt) begin
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
         end
      end
   end

   assign bus.mem_we    = r_mem_we;
   assign bus.mem_oe    = r_mem_oe;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;

   assign w_tag_in = make_tag(w_any_gnt && !w_sel_we, w_dma_gnt ? REQ_DMA : REQ_CPU);

   mem_arb_tag_pipe #(
      .DEPTH (READ_LATENCY + 1)
   ) u_tag_pipe (
      .clk   (clk),
      .reset (reset),
      .i_tag (w_tag_in),
      .o_tap (w_tag_tap),
      .o_tag (w_tag_out)
   );

   // Only the owner of the returning read captures mem_rdata; the other side holds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cpu_rdata <= '0;
         r_dma_rdata <= '0;
      end else if (w_tag_tap.valid) begin
         if (w_tag_tap.id == REQ_DMA) begin
            r_dma_rdata <= bus.mem_rdata;
         end else begin
            r_cpu_rdata <= bus.mem_rdata;
         end
      end
   end

   assign bus.cpu_rvalid = w_tag_out.valid && (w_tag_out.id == REQ_CPU);
   assign bus.dma_rvalid = w_tag_out.valid && (w_tag_out.id == REQ_DMA);
   assign bus.cpu_rdata  = r_cpu_rdata;
   assign bus.dma_rdata  = r_dma_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: reads push expected returns, a negedge monitor pops them.
// A behavioural memory answers mem_oe one cycle later; the bench keeps its own shadow copy.
module tb_mem_arbiter;

   localparam int RL = 2;

   typedef struct {
      bit         dma;
      logic [7:0] data;
      int         cyc;
   } sb_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_err = 0;
   sb_t  sb[$];

   logic [7:0] mem_arr    [0:32767];
   bit         mem_wr     [0:32767];
   logic [7:0] shadow     [0:32767];
   bit         shadow_wr  [0:32767];
   logic [7:0] rd_q = 8'h00;

   mem_arbiter_if #(.ADDR_W(15)) bus ();

   mem_arbiter #(
      .ADDR_W         (15),
      .READ_LATENCY   (RL),
      .MAX_CPU_STREAK (4),
      .ROM_BASE       (15'h6000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] init_val(input logic [14:0] a);
      case (a)
         15'h1FFC: return 8'h00;
         15'h1FFD: return 8'h80;
         15'h0010: return 8'h11;
         15'h0020: return 8'h22;
         15'h0030: return 8'h33;
         default:  return a[7:0] ^ 8'h5A;
      endcase
   endfunction

   function automatic bit is_prot(input logic [14:0] a);
`ifdef MEM_ARB_WRPROT_EN
      return a >= 15'h6000;
`else
      return (a != a);
`endif
   endfunction

   always @(posedge clk) begin
      if (bus.mem_we) begin
         mem_arr[bus.mem_addr] <= bus.mem_wdata;
         mem_wr[bus.mem_addr]  <= 1'b1;
      end
      if (bus.mem_oe) begin
         rd_q <= mem_wr[bus.mem_addr] ? mem_arr[bus.mem_addr] : init_val(bus.mem_addr);
      end
   end
   assign bus.mem_rdata = rd_q;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic issue(input bit is_dma, input logic we, input logic [14:0] a, input logic [7:0] d);
      sb_t e;
      if (we) begin
         if (!is_prot(a)) begin
            shadow[a]    = d;
            shadow_wr[a] = 1'b1;
         end
      end else begin
         e.dma  = is_dma;
         e.data = shadow_wr[a] ? shadow[a] : init_val(a);
         e.cyc  = cyc + 1 + RL;
         sb.push_back(e);
      end
   endtask

   // Called at posedge+1; returns at the next posedge+1. exp_g: 0 none, 1 CPU, 2 DMA.
   task automatic step(input logic c_req, input logic c_we, input logic [14:0] c_addr, input logic [7:0] c_wd,
                       input logic d_req, input logic d_we, input logic [14:0] d_addr, input logic [7:0] d_wd,
                       input int exp_g, input string tag);
      bus.cpu_req   = c_req;
      bus.cpu_we    = c_we;
      bus.cpu_addr  = c_addr;
      bus.cpu_wdata = c_wd;
      bus.dma_req   = d_req;
      bus.dma_we    = d_we;
      bus.dma_addr  = d_addr;
      bus.dma_wdata = d_wd;
      #2;
      chk({tag, ".cpu_gnt"}, 32'(bus.cpu_gnt), 32'(exp_g == 1));
      chk({tag, ".dma_gnt"}, 32'(bus.dma_gnt), 32'(exp_g == 2));
      if (exp_g == 1) issue(1'b0, c_we, c_addr, c_wd);
      else if (exp_g == 2) issue(1'b1, d_we, d_addr, d_wd);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 15'h0, 8'h0, 0, 0, 15'h0, 8'h0, 0, "idle");
   endtask

   always @(negedge clk) begin
      sb_t e;
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
         chk("rv_missing", 32'(cyc), 32'(sb[0].cyc));
         sb.delete(0);
      end
      if (bus.cpu_rvalid || bus.dma_rvalid) begin
         if (sb.size() == 0) begin
            chk("rv_spurious", 32'({bus.cpu_rvalid, bus.dma_rvalid}), 32'd0);
         end else begin
            e = sb[0];
            sb.delete(0);
            chk("rv_pair", 32'({bus.cpu_rvalid, bus.dma_rvalid}), e.dma ? 32'd1 : 32'd2);
            chk("rv_data", 32'(e.dma ? bus.dma_rdata : bus.cpu_rdata), 32'(e.data));
            chk("rv_cycle", 32'(cyc), 32'(e.cyc));
            $display("read %s data=%02h cycle=%0d", e.dma ? "dma" : "cpu",
                     e.dma ? bus.dma_rdata : bus.cpu_rdata, cyc);
         end
      end
   end

   initial begin
      bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.mem_we",     32'(bus.mem_we),     32'd0);
      chk("rst.mem_oe",     32'(bus.mem_oe),     32'd0);
      chk("rst.mem_addr",   32'(bus.mem_addr),   32'd0);
      chk("rst.cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
      chk("rst.dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
      chk("rst.prot_err",   32'(bus.prot_err),   32'd0);
      reset = 1'b0;
      idle(2);

      // CPU-only back-to-back reads
      step(1, 0, 15'h1FFC, 8'h00, 0, 0, 15'h0, 8'h0, 1, "t1a");
      chk("t1.mem_oe",   32'(bus.mem_oe),   32'd1);
      chk("t1.mem_we",   32'(bus.mem_we),   32'd0);
      chk("t1.mem_addr", 32'(bus.mem_addr), 32'h1FFC);
      step(1, 0, 15'h1FFD, 8'h00, 0, 0, 15'h0, 8'h0, 1, "t1b");
      chk("t1.mem_addr2", 32'(bus.mem_addr), 32'h1FFD);
      idle(5);

      // Both requesting continuously: C,C,C,C,D repeating
      for (int i = 0; i < 10; i++) begin
         step(1, 0, 15'(15'h0200 + i), 8'h00, 1, 0, 15'(15'h0300 + i), 8'h00,
              ((i % 5) == 4) ? 2 : 1, $sformatf("t2_%0d", i));
      end
      idle(5);

      // DMA write then CPU read of the same address
      step(0, 0, 15'h0, 8'h0, 1, 1, 15'h0100, 8'hEA, 2, "t3w");
      chk("t3.mem_we",    32'(bus.mem_we),    32'd1);
      chk("t3.mem_oe",    32'(bus.mem_oe),    32'd0);
      chk("t3.mem_addr",  32'(bus.mem_addr),  32'h0100);
      chk("t3.mem_wdata", 32'(bus.mem_wdata), 32'hEA);
      step(1, 0, 15'h0100, 8'h00, 0, 0, 15'h0, 8'h0, 1, "t3r");
      chk("t3.mem_we_off", 32'(bus.mem_we), 32'd0);
      chk("t3.mem_oe_on",  32'(bus.mem_oe), 32'd1);
      idle(5);

      // Interleaved CPU/DMA/CPU reads return in issue order
      step(1, 0, 15'h0010, 8'h00, 0, 0, 15'h0, 8'h0, 1, "t4a");
      step(0, 0, 15'h0, 8'h00, 1, 0, 15'h0020, 8'h0, 2, "t4b");
      step(1, 0, 15'h0030, 8'h00, 0, 0, 15'h0, 8'h0, 1, "t4c");
      idle(5);

      // Write into the protected region
      step(1, 1, 15'h6000, 8'h77, 0, 0, 15'h0, 8'h0, 1, "t5");
      chk("t5.mem_we",   32'(bus.mem_we),   is_prot(15'h6000) ? 32'd0 : 32'd1);
      chk("t5.prot_err", 32'(bus.prot_err), is_prot(15'h6000) ? 32'd1 : 32'd0);
      idle(3);
      chk("t5.idle_we",    32'(bus.mem_we),   32'd0);
      chk("t5.idle_oe",    32'(bus.mem_oe),   32'd0);
      chk("t5.prot_stick", 32'(bus.prot_err), is_prot(15'h6000) ? 32'd1 : 32'd0);

      // Reset with two reads in flight
      step(1, 0, 15'h0040, 8'h00, 0, 0, 15'h0, 8'h0, 1, "t6a");
      step(0, 0, 15'h0, 8'h00, 1, 0, 15'h0050, 8'h0, 2, "t6b");
      bus.cpu_req = 0;
      bus.dma_req = 0;
      reset = 1'b1;
      sb.delete();
      #1;
      chk("t6.mem_oe",     32'(bus.mem_oe),     32'd0);
      chk("t6.mem_addr",   32'(bus.mem_addr),   32'd0);
      chk("t6.mem_wdata",  32'(bus.mem_wdata),  32'd0);
      chk("t6.cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
      chk("t6.dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
      chk("t6.cpu_rdata",  32'(bus.cpu_rdata),  32'd0);
      chk("t6.dma_rdata",  32'(bus.dma_rdata),  32'd0);
      chk("t6.prot_err",   32'(bus.prot_err),   32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      idle(6);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
